// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead FIFO onto a UART line.
// Each popped word is sent as 1 start bit, DBIT data bits (LSB first)
// and SB_TICK/16 stop bits, timed by an internal 16x oversampling tick.
// Optional feature: define FIFO_UART_TX_PARITY_EN to insert an even-parity
// bit between the data bits and the stop bit(s).
module fifo_uart_tx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_enable,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  // The tick counter s covers 16 ticks per bit and also the stop period.
  localparam int SB_W = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
  localparam int S_W  = (SB_W > 4) ? SB_W : 4;
  localparam int N_W  = (DBIT > 1) ? $clog2(DBIT) : 1;

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_n;
  logic [DVSR_W-1:0] baud, baud_n;
  logic              tick;
  logic [S_W-1:0]    s, s_n;
  logic [N_W-1:0]    n, n_n;
  logic [DBIT-1:0]   shreg, shreg_n;
  logic              tx_n;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              par, par_n;
`endif

  // Baud tick fires on the last clk of each oversampling period; it is
  // suppressed in IDLE so every frame starts on a fresh period.
  assign tick    = (state != IDLE) && (baud == DVSR_W'(DVSR - 1));
  assign tx_busy = (state != IDLE);

  // Baud counter: held at 0 in IDLE, otherwise wraps at DVSR-1.
  always_comb begin
    baud_n = '0;
    if (state != IDLE && !tick) begin
      baud_n = baud + DVSR_W'(1);
    end
  end

  // Next-state, pop strobe, done pulse and next line level.
  always_comb begin
    state_n      = state;
    s_n          = s;
    n_n          = n;
    shreg_n      = shreg;
    fifo_rd      = 1'b0;
    tx_done_tick = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    par_n        = par;
`endif
    case (state)
      IDLE: begin
        // Pop is gated by reset so a word is never consumed and then dropped.
        if (tx_enable && !fifo_empty && !reset) begin
          fifo_rd = 1'b1;
          shreg_n = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          par_n   = ^fifo_data;
`endif
          s_n     = '0;
          n_n     = '0;
          state_n = START;
        end
      end
      START: begin
        if (tick) begin
          if (s == S_W'(15)) begin
            s_n     = '0;
            n_n     = '0;
            state_n = DATA;
          end else begin
            s_n = s + S_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s == S_W'(15)) begin
            s_n     = '0;
            shreg_n = shreg >> 1;
            if (n == N_W'(DBIT - 1)) begin
`ifdef FIFO_UART_TX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              n_n = n + N_W'(1);
            end
          end else begin
            s_n = s + S_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s == S_W'(15)) begin
            s_n     = '0;
            state_n = STOP;
          end else begin
            s_n = s + S_W'(1);
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s == S_W'(SB_TICK - 1)) begin
            s_n          = '0;
            tx_done_tick = !reset;
            state_n      = IDLE;
          end else begin
            s_n = s + S_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is decided from the next state so tx can be registered
    // and still change in the same cycle as the state does.
    tx_n = 1'b1;
    case (state_n)
      IDLE:    tx_n = 1'b1;
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_n = par_n;
`endif
      STOP:    tx_n = 1'b1;
      default: tx_n = 1'b1;
    endcase
  end

  // Control registers: state, counters and the glitch-free line driver.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      baud  <= '0;
      s     <= '0;
      n     <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      s     <= s_n;
      n     <= n_n;
      tx    <= tx_n;
    end
  end

  // Data registers: only meaningful once loaded by a pop, so left unreset.
  always_ff @(posedge clk) begin
    shreg <= shreg_n;
`ifdef FIFO_UART_TX_PARITY_EN
    par   <= par_n;
`endif
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: scoreboard bench for fifo_uart_tx. A queue-based FIFO
// model feeds the DUT; words pushed by the stimulus are also queued as
// expected frames, and a monitor rebuilds each frame from the line.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int DBIT    = 8;
  localparam int SB_TICK = 16;
  localparam int DVSR_W  = 8;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int DVSR    = 1;
  localparam int PB      = 1;
`else
  localparam int DVSR    = 2;
  localparam int PB      = 0;
`endif
  localparam int BITLEN  = 16 * DVSR;
  localparam int L       = (1 + DBIT + PB) * BITLEN + SB_TICK * DVSR;

  logic            clk;
  logic            reset;
  logic            tx_enable;
  logic            fifo_empty;
  logic [DBIT-1:0] fifo_data;
  logic            fifo_rd;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  fifo_uart_tx #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK),
    .DVSR    (DVSR),
    .DVSR_W  (DVSR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_enable    (tx_enable),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd      (fifo_rd),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [DBIT-1:0] fifo_q[$];
  logic [DBIT-1:0] exp_q[$];

  bit              mon_en, active, gap_pending, post_reset, pop_req;
  int              cyc, t, wave_err, busy_err, done_err;
  int              rd_count, done_count, frames_done;
  int              last_rd_cyc, prev_rd_cyc, last_done_cyc;
  logic [DBIT-1:0] cur, dec;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail_now(input string name, input int budget);
    n_checks++;
    $display("FAIL %s: no progress within %0d cycles", name, budget);
  endtask

  task automatic refresh();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DBIT-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    refresh();
  endtask

  // Line level expected t cycles into a frame carrying word w.
  function automatic logic exp_bit(input logic [DBIT-1:0] w, input int tt);
    int idx;
    idx = (tt - 1) / BITLEN;
    if (idx == 0) return 1'b0;
    if (idx <= DBIT) return w[3'(idx - 1)];
`ifdef FIFO_UART_TX_PARITY_EN
    if (idx == DBIT + 1) return ^w;
`endif
    return 1'b1;
  endfunction

  // FIFO model: a pop seen during a cycle takes effect just after the edge.
  always @(posedge clk) begin
    #1;
    if (pop_req) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_req = 1'b0;
    end
    refresh();
  end

  // Monitor: samples mid-cycle, checks pops and rebuilds frames from tx.
  always @(negedge clk) begin
    bit was_active;
    bit rd_exp;
    int idx;
    int pos;
    cyc++;
    if (mon_en) begin
      was_active = active;
      if (post_reset) begin
        check("post_reset_tx", 32'(tx), 32'd1);
        check("post_reset_busy", 32'(tx_busy), 32'd0);
        check("post_reset_done", 32'(tx_done_tick), 32'd0);
        post_reset = 1'b0;
      end
      if (gap_pending) begin
        check("gap_tx", 32'(tx), 32'd1);
        check("gap_busy", 32'(tx_busy), 32'd0);
        gap_pending = 1'b0;
      end
      rd_exp = !was_active && tx_enable && !fifo_empty && !reset;
      if (rd_exp || fifo_rd) check("fifo_rd", 32'(fifo_rd), 32'(rd_exp));
      if (tx_done_tick) begin
        done_count++;
        last_done_cyc = cyc;
      end
      if (reset && was_active) begin
        active = 1'b0;
      end else if (was_active) begin
        t++;
        idx = (t - 1) / BITLEN;
        pos = (t - 1) % BITLEN;
        if (tx !== exp_bit(cur, t)) wave_err++;
        if (tx_busy !== 1'b1) busy_err++;
        if (pos == BITLEN / 2 && idx == 0) check("start_bit", 32'(tx), 32'd0);
        if (pos == BITLEN / 2 && idx >= 1 && idx <= DBIT) dec[3'(idx - 1)] = tx;
`ifdef FIFO_UART_TX_PARITY_EN
        if (pos == BITLEN / 2 && idx == DBIT + 1) check("parity_bit", 32'(tx), 32'(^cur));
`endif
        if (t == L - (SB_TICK * DVSR) / 2) check("stop_bit", 32'(tx), 32'd1);
        if (t < L && tx_done_tick) done_err++;
        if (t == L) begin
          check("done_tick", 32'(tx_done_tick), 32'd1);
          check("data", 32'(dec), 32'(cur));
          check("wave_err", 32'(wave_err), 32'd0);
          check("busy_err", 32'(busy_err), 32'd0);
          check("early_done", 32'(done_err), 32'd0);
          active      = 1'b0;
          gap_pending = 1'b1;
          frames_done++;
        end
      end else if (tx_done_tick) begin
        check("spurious_done", 32'(tx_done_tick), 32'd0);
      end
      if (fifo_rd) pop_req = 1'b1;
      if (fifo_rd && !was_active) begin
        rd_count++;
        prev_rd_cyc = last_rd_cyc;
        last_rd_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL exp_q: pop with no word expected (cycle %0d)", cyc);
          cur = '0;
        end else begin
          cur = exp_q.pop_front();
        end
        active   = 1'b1;
        t        = 0;
        wave_err = 0;
        busy_err = 0;
        done_err = 0;
        dec      = '0;
      end
      if (reset) post_reset = 1'b1;
    end
  end

  task automatic wait_rd(input string name, input int budget);
    int  start;
    bit  ok;
    start = rd_count;
    ok    = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (rd_count != start) ok = 1'b1;
    end
    if (!ok) fail_now(name, budget);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(posedge clk);
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !active && !gap_pending && !pop_req) ok = 1'b1;
    end
    if (!ok) fail_now(name, budget);
    repeat (2) @(posedge clk);
    #2;
  endtask

  initial begin
    int bad;
    int rd0;
    int done0;
    int frames0;
    int gap;
    reset     = 1'b1;
    tx_enable = 1'b0;
    refresh();
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(tx_busy), 32'd0);
    check("reset_rd", 32'(fifo_rd), 32'd0);
    check("reset_done", 32'(tx_done_tick), 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // Single frame of A5.
    push(8'hA5);
    tx_enable = 1'b1;
    wait_idle("t1_idle", 4 * L);
    check("t1_latency", 32'(last_done_cyc - last_rd_cyc), 32'(L));

    // Two queued words go out back to back.
    rd0   = rd_count;
    done0 = done_count;
    push(8'h55);
    push(8'h0F);
    wait_idle("t2_idle", 6 * L);
    check("t2_rd_count", 32'(rd_count - rd0), 32'd2);
    check("t2_done_count", 32'(done_count - done0), 32'd2);
    check("t2_rd_spacing", 32'(last_rd_cyc - prev_rd_cyc), 32'(L + 1));

    // Empty FIFO with enable held: line stays idle.
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fifo_rd || tx !== 1'b1 || tx_busy) bad++;
    end
    check("t3_idle_bad", 32'(bad), 32'd0);
    @(posedge clk);
    #2;

    // Enable dropped mid-frame: frame completes, no further pop.
    rd0     = rd_count;
    frames0 = frames_done;
    push(8'h3C);
    wait_rd("t4_rd", 200);
    repeat (50) @(posedge clk);
    #2;
    tx_enable = 1'b0;
    push(8'h81);
    repeat (L + 400) @(posedge clk);
    #2;
    check("t4_frames", 32'(frames_done - frames0), 32'd1);
    check("t4_no_rd", 32'(rd_count - rd0), 32'd1);
    tx_enable = 1'b1;
    wait_idle("t4_idle", 4 * L);

    // Reset 100 cycles into a frame: frame lost, no done pulse.
    push(8'hC3);
    wait_rd("t5_rd", 200);
    done0   = done_count;
    frames0 = frames_done;
    repeat (100) @(posedge clk);
    #2;
    reset = 1'b1;
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (L) @(posedge clk);
    #2;
    check("t5_no_done", 32'(done_count - done0), 32'd0);
    check("t5_no_frame", 32'(frames_done - frames0), 32'd0);
    push(8'h5A);
    wait_idle("t5_idle", 4 * L);

    // Parity sample word, then randomized traffic with enable gaps.
    push(8'h07);
    wait_idle("t6_idle", 4 * L);
    check("t6_latency", 32'(last_done_cyc - last_rd_cyc), 32'(L));
    for (int k = 0; k < 8; k++) begin
      push(8'($urandom_range(0, 255)));
      gap = int'($urandom_range(0, 400));
      repeat (gap) @(posedge clk);
      #2;
      if ($urandom_range(0, 3) == 0) begin
        tx_enable = 1'b0;
        repeat ($urandom_range(1, 300)) @(posedge clk);
        #2;
        tx_enable = 1'b1;
      end
    end
    wait_idle("rand_idle", 12 * L);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drain side for the team's buffered serial path. Pops words from a standard show-ahead FIFO (`empty`, `rd`, `r_data` style interface) and serialises each word onto a UART line: 1 start bit, DBIT data bits LSB first, stop bit(s).
- Sits between the transmit FIFO and the chip pin.
- Baud-rate tick generator is internal. Bit timing uses 16x oversampling ticks.

Parameters:
- DBIT, 8, data bits per frame; also the fifo_data width.
- SB_TICK, 16, ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- DVSR, 163, clk cycles per oversampling tick; must be >= 1.
- DVSR_W, 8, width of the baud counter; must satisfy 2**DVSR_W >= DVSR.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- tx_enable  input  1  permits starting a new frame
- fifo_empty  input  1  FIFO empty flag
- fifo_data  input  DBIT  FIFO head word; valid whenever fifo_empty=0
- fifo_rd  output  1  one-cycle pop strobe to the FIFO
- tx  output  1  serial line, idle high
- tx_busy  output  1  high while a frame is in progress
- tx_done_tick  output  1  one-cycle pulse at the end of the stop state

Behaviour:
- One clock. Reset is synchronous and active-high; everything is sampled on posedge clk.
- Reset values: tx=1, fifo_rd=0, tx_busy=0, tx_done_tick=0, state=IDLE, all counters 0.
- Baud counter:
  - Held at 0 in IDLE.
  - Otherwise counts 0..DVSR-1 and wraps.
  - tick=1 in the cycle the counter equals DVSR-1.
  - DVSR=1 gives tick every cycle.
- States: IDLE, START, DATA, [PARITY], STOP. Counter s is 4-bit (0..15); stop uses a counter wide enough for SB_TICK-1. Counter n runs 0..DBIT-1.
- IDLE:
  - tx=1, tx_busy=0.
  - When tx_enable=1 and fifo_empty=0: latch fifo_data into the shift register, assert fifo_rd for exactly that one cycle, then go to START with s=0.
  - fifo_rd is never asserted while fifo_empty=1.
- START: tx=0. On each tick, s increments. On a tick with s=15, go to DATA with s=0, n=0.
- DATA:
  - tx=shift_reg[0].
  - On a tick with s=15: shift right by one and set s=0.
  - If n=DBIT-1, go to STOP (or PARITY); else n increments.
- STOP: tx=1. On a tick with s=SB_TICK-1: pulse tx_done_tick for 1 cycle and go to IDLE.
- tx_busy=1 in every state except IDLE. It first asserts in the cycle after the fifo_rd pulse.
- Frame latency: first start-bit cycle is the cycle after fifo_rd. Frame length is exactly (1+DBIT)*16*DVSR + SB_TICK*DVSR cycles.
- Back-to-back frames: the earliest next fifo_rd is the cycle after tx_done_tick, which gives 1 idle-high cycle between frames.
- tx_enable deasserted mid-frame: the current frame completes and no new pop occurs.
- fifo_empty changes mid-frame: ignored.
- Reset mid-frame: the frame is aborted and tx=1 from the next cycle. The popped word is lost; no tx_done_tick.
- tx is a registered output (glitch-free).

Optional Feature:
- Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA.
  - tx = even parity (XOR of the DBIT latched bits) for 16 ticks, then STOP.
  - Frame length increases by 16*DVSR cycles.
- Undefined: no PARITY state, no parity logic; DATA goes directly to STOP.

Test Plan:
1. Reset, then fifo_empty=0, fifo_data=8'hA5, tx_enable=1, DVSR=2 -> fifo_rd high for 1 cycle. tx sequence: 0,1,0,1,0,0,1,0,1,1, each bit 32 cycles. tx_done_tick at cycle 320 after fifo_rd.
2. FIFO model holding 8'h55 then 8'h0F, tx_enable held -> exactly 2 fifo_rd pulses, 321 cycles apart. 2 tx_done_ticks. Decoded bytes 55, 0F.
3. fifo_empty=1, tx_enable=1 for 1000 cycles -> fifo_rd=0, tx=1, tx_busy=0 throughout.
4. tx_enable dropped 50 cycles into a frame of 8'h3C -> frame completes correctly; no further fifo_rd although fifo_empty=0.
5. reset asserted 100 cycles into a frame -> next cycle tx=1, tx_busy=0, no tx_done_tick. A new frame starts correctly after reset is released.
6. With FIFO_UART_TX_PARITY_EN defined, DVSR=1, data 8'h07 -> parity bit=1 for 16 cycles. Total frame 176 cycles.
